// File: rtl/adder_tree_arbiter_pkg.sv
// Shared types for the adder-tree arbiter: control states, in-flight tag
// format and the tree sum-width helper.
package adder_tree_pkg;

    // Wide enough for up to 8 requesters; narrower IDs are zero-extended.
    localparam int MAX_ID_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    function automatic int sum_width(input int dw, input int ni);
        return dw + $clog2(ni - 1) + 2;
    endfunction

endpackage

// File: rtl/adder_tree_arbiter_rr.sv
// Round-robin pick: the first set request at or after ptr+1 (mod NUM_REQ)
// wins; grant is one-hot and idx its binary index.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan by rotated distance from ptr+1 so the lowest distance wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!any && req[i] && ((i + NUM_REQ - 1 - int'(ptr)) % NUM_REQ == k)) begin
                    any      = 1'b1;
                    grant[i] = 1'b1;
                    idx      = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/adder_tree_arbiter.sv
// Shares one pipelined adder tree among NUM_REQ requesters: round-robin
// grant, requester tag tracked alongside the tree, sum routed back.
module adder_tree_arbiter
    import adder_tree_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int DATAWIDTH    = 4,
    parameter  int NUM_INPUTS   = 16,
    parameter  int TREE_LATENCY = 1,
    localparam int SUM_W        = sum_width(DATAWIDTH, NUM_INPUTS)
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             en,
    input  logic [NUM_REQ-1:0]                               req_valid,
    input  logic [NUM_REQ-1:0][NUM_INPUTS-1:0][DATAWIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                               req_ready,
    output logic                                             tree_i_valid,
    output logic [NUM_INPUTS-1:0][DATAWIDTH-1:0]             tree_in_data,
    input  logic                                             tree_o_valid,
    input  logic [SUM_W-1:0]                                 tree_sum,
    output logic [NUM_REQ-1:0]                               rsp_valid,
    output logic [SUM_W-1:0]                                 rsp_sum,
    output logic                                             idle,
    output logic                                             err
);

    localparam int ID_W = $clog2(NUM_REQ);

    ctrl_state_e                          state;
    logic [ID_W-1:0]                      ptr;
    logic [ID_W-1:0]                      gnt_idx;
    logic [NUM_REQ-1:0]                   gnt_raw;
    logic                                 gnt_any;
    logic                                 grant_ok;
    logic [NUM_INPUTS-1:0][DATAWIDTH-1:0] held;
    tag_t                                 tag_in;
    tag_t                                 tag_out;
    logic                                 in_flight;
    logic                                 hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (gnt_raw),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign grant_ok     = (state == RUN) && gnt_any;
    assign req_ready    = grant_ok ? gnt_raw : '0;
    assign tree_i_valid = grant_ok;
    // The tree sees the operands in the grant cycle; otherwise the last vector is held.
    assign tree_in_data = grant_ok ? req_data[gnt_idx] : held;

    assign tag_in = '{valid: grant_ok, id: MAX_ID_W'(gnt_idx)};

    generate
        if (TREE_LATENCY == 0) begin : g_pass
            assign tag_out   = tag_in;
            assign in_flight = 1'b0;
        end else begin : g_pipe
            tag_t pipe [TREE_LATENCY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < TREE_LATENCY; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= tag_in;
                    for (int i = 1; i < TREE_LATENCY; i++) pipe[i] <= pipe[i-1];
                end
            end

            always_comb begin
                in_flight = 1'b0;
                for (int i = 0; i < TREE_LATENCY; i++) in_flight = in_flight | pipe[i].valid;
            end

            assign tag_out = pipe[TREE_LATENCY-1];
        end
    endgenerate

    assign hit = tag_out.valid & tree_o_valid;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = hit && (tag_out.id == MAX_ID_W'(i));
        end
    end

    assign rsp_sum = tree_sum;
    assign idle    = (state == IDLE) && !in_flight;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= ID_W'(NUM_REQ - 1);
            held  <= '0;
            err   <= 1'b0;
        end else begin
            if (grant_ok) begin
                ptr  <= gnt_idx;
                held <= req_data[gnt_idx];
            end
            // A tree result without a tag (or a tag without a result) means lost sync.
            if (tag_out.valid != tree_o_valid) err <= 1'b1;
            case (state)
                IDLE:    if (en) state <= RUN;
                RUN:     if (!en) state <= DRAIN;
                DRAIN: begin
                    if (en)              state <= RUN;
                    else if (!in_flight) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
